gpia_wb_ctrl: RTL and testbench
===============================

# gpia_wb_ctrl

Bus-side controller for a GPIA port of WIDTH bits. It owns the output-data (PORT) and data-direction (DDR) registers and synchronizes the external pins. It answers single-cycle-acknowledged Wishbone classic read/write cycles, sequencing the per-bit read-back rule: DDR=1 returns the PORT bit, DDR=0 returns the synchronized pin. It sits between the processor's I/O bus and the pad drivers.

## Interface
- WIDTH, 16, bits per port.
- SYNC_STAGES, 2, pin synchronizer depth (≥2).
- clk_i  in  1  sole clock; all state changes on rising edge.
- reset_i  in  1  reset, synchronous, active-low.
- cyc_i  in  1  bus cycle in progress.
- stb_i  in  1  strobe; request = cyc_i & stb_i & ~ack_o.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  2  register select: 0 INPUT (RO), 1 PORT (RW), 2 DDR (RW), 3 EDGE (see Configuration).
- dat_i  in  WIDTH  write data.
- dat_o  out  WIDTH  read data, registered, valid while ack_o=1, else 0.
- ack_o  out  1  one-cycle acknowledge.
- pins_i  in  WIDTH  asynchronous external pin levels.
- port_o  out  WIDTH  PORT register to pad drivers.
- ddr_o  out  WIDTH  DDR register to pad output enables (1 = drive).
- irq_o  out  1  OR of EDGE flags; constant 0 when feature is compiled out.

## Operation
- States: IDLE, ACK (two-state FSM). Reset → IDLE.
- IDLE: on request → ACK; write performed and read data captured on that edge.
- ACK: ack_o=1 for exactly one cycle → IDLE unconditionally, even if stb_i remains high. A held strobe is re-accepted in the next IDLE cycle, so back-to-back transfers occur every 2 cycles.
- Write adr 1 → PORT ← dat_i. Write adr 2 → DDR ← dat_i. Write adr 0 is ignored but still acknowledged.
- Read adr 0 → per bit: DDR[i] ? PORT[i] : sync[i]. Read adr 1 → PORT. Read adr 2 → DDR.
- Read of adr 0 uses PORT/DDR values from before any same-edge write; no write can coincide with a read anyway.
- cyc_i=0 with stb_i=1 is not a request. A cyc_i drop during ACK does not cancel the ack.
- Synchronizer: SYNC_STAGES flops per bit; sync = last stage.
- Reset values: port_o=0, ddr_o=0 (all pins input), ack_o=0, dat_o=0, sync chain=0, EDGE=0, irq_o=0.
- Reset asserted while in ACK: the next edge forces IDLE with ack_o=0. A write presented on the reset edge is discarded.

## Timing
- Request sampled at edge N → ack_o and dat_o valid after edge N, dropped after edge N+1.
- Write visible on port_o/ddr_o after edge N (same edge ack rises).
- Pin change → readable at adr 0 no earlier than SYNC_STAGES edges later, plus the read's capture edge.
- DDR change takes effect on adr-0 read-back from the next request onward.

## Configuration
- GPIA_INPUT_EDGE_EN defined:
  - EDGE[i] sets when sync[i] goes 0→1 (previous-sync flop added).
  - Read adr 3 returns EDGE. Write adr 3 is write-1-to-clear.
  - Set and clear on the same edge → set wins.
  - irq_o = |EDGE.
- Undefined:
  - Adr 3 reads 0; writes to it are acknowledged and ignored.
  - irq_o tied 0; no edge flops.

## Structure
- gpia_pkg: address constants ADR_INPUT=2'd0, ADR_PORT=2'd1, ADR_DDR=2'd2, ADR_EDGE=2'd3; FSM state type {IDLE, ACK}.
- Sub-module gpia_sync: parameterized WIDTH×SYNC_STAGES flop chain with synchronous active-low reset, instantiated once.

## Test plan
- Reset: hold reset_i=0 for 2 clocks with pins_i=16'hFFFF → port_o=0, ddr_o=0, ack_o=0, dat_o=0; adr-0 read after release + 3 clocks returns 16'hFFFF.
- Write PORT 16'hA5A5, DDR 16'h00FF, pins_i=16'h5A5A → ack_o high exactly 1 cycle per write; adr-0 read returns 16'h5AA5; adr 1/2 read back 16'hA5A5/16'h00FF.
- Strobe held high 6 cycles on a read → ack_o pattern 1,0,1,0,1,0; dat_o=0 in non-ack cycles.
- Pin 3 toggles 0→1, adr-0 read issued 1 clock later → bit 3 still 0; read issued after SYNC_STAGES clocks → bit 3 = 1.
- Reset asserted on the cycle ack_o=1 → ack_o=0 next cycle; a write of 16'h1234 to PORT on the reset edge leaves port_o=0.
- With GPIA_INPUT_EDGE_EN: pin 0 rises → EDGE=16'h0001, irq_o=1; write 16'h0001 to adr 3 coincident with a new rise on pin 0 → flag stays 1. A later clear with no rise → EDGE=0, irq_o=0. Without the macro: adr-3 read returns 0 and irq_o=0 throughout.

Source files
------------

// File: rtl/gpia_pkg.sv
// Shared definitions for the GPIA Wishbone controller: register addresses
// and the bus handshake FSM state type.
package gpia_pkg;

  localparam logic [1:0] ADR_INPUT = 2'd0;
  localparam logic [1:0] ADR_PORT  = 2'd1;
  localparam logic [1:0] ADR_DDR   = 2'd2;
  localparam logic [1:0] ADR_EDGE  = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } gpia_state_e;

endpackage

// File: rtl/gpia_sync.sv
// Multi-stage flop chain that brings asynchronous pin levels into the clk_i
// domain. Synchronous active-low reset clears every stage.
module gpia_sync #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_chain [SYNC_STAGES];

  // Shift the pin sample one stage per clock.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        r_chain[s] <= '0;
      end
    end else begin
      r_chain[0] <= d_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        r_chain[s] <= r_chain[s-1];
      end
    end
  end

  assign q_o = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpia_wb_ctrl.sv
// Wishbone classic slave owning the GPIA PORT and DDR registers plus the pin
// synchronizer. Every accepted request is acknowledged for exactly one cycle.
// Optional feature: define GPIA_INPUT_EDGE_EN to add rising-edge flags (EDGE,
// write-1-to-clear at address 3) and the irq_o output.
module gpia_wb_ctrl
  import gpia_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [1:0]       adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             ack_o,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] port_o,
  output logic [WIDTH-1:0] ddr_o,
  output logic             irq_o
);

  gpia_state_e      r_state;
  gpia_state_e      w_state_next;
  logic             w_req;
  logic             w_wr;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rd_data;
  logic [WIDTH-1:0] r_port;
  logic [WIDTH-1:0] r_ddr;
  logic [WIDTH-1:0] r_dat;

  gpia_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (pins_i),
    .q_o     (w_sync)
  );

  // Handshake state register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and request decode; ACK always returns to IDLE so a held
  // strobe is served every second cycle.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cyc_i && stb_i) begin
          w_req        = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign ack_o = (r_state == ACK);
  assign w_wr  = w_req & we_i;

`ifdef GPIA_INPUT_EDGE_EN
  logic [WIDTH-1:0] r_sync_prev;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] w_edge_set;
  logic [WIDTH-1:0] w_edge_clr;

  // Rising-edge detect and write-1-to-clear mask; a set beats a clear.
  always_comb begin
    w_edge_set = w_sync & ~r_sync_prev;
    w_edge_clr = (w_wr && (adr_i == ADR_EDGE)) ? dat_i : '0;
  end

  // Edge flag and previous-sync registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_sync_prev <= '0;
      r_edge      <= '0;
    end else begin
      r_sync_prev <= w_sync;
      r_edge      <= (r_edge & ~w_edge_clr) | w_edge_set;
    end
  end

  assign irq_o = |r_edge;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux; INPUT shows PORT for driven bits and the synchronized pin
  // for bits configured as inputs.
  always_comb begin
    w_rd_data = '0;
    unique case (adr_i)
      ADR_INPUT: w_rd_data = (r_ddr & r_port) | (~r_ddr & w_sync);
      ADR_PORT:  w_rd_data = r_port;
      ADR_DDR:   w_rd_data = r_ddr;
      ADR_EDGE: begin
`ifdef GPIA_INPUT_EDGE_EN
        w_rd_data = r_edge;
`else
        w_rd_data = '0;
`endif
      end
      default:   w_rd_data = '0;
    endcase
  end

  // PORT/DDR writes; reset wins over any write presented on the same edge.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_port <= '0;
      r_ddr  <= '0;
    end else begin
      if (w_wr && (adr_i == ADR_PORT)) begin
        r_port <= dat_i;
      end
      if (w_wr && (adr_i == ADR_DDR)) begin
        r_ddr <= dat_i;
      end
    end
  end

  // Read data is captured with the request and zeroed outside the ack cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_dat <= '0;
    end else if (w_req && !we_i) begin
      r_dat <= w_rd_data;
    end else begin
      r_dat <= '0;
    end
  end

  assign dat_o  = r_dat;
  assign port_o = r_port;
  assign ddr_o  = r_ddr;

endmodule

// File: tb/tb_gpia_wb_ctrl.sv
// Self-checking bench for gpia_wb_ctrl: directed scenarios plus a randomized
// sequence checked against a register-level reference model.
module tb_gpia_wb_ctrl;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned SYNC_STAGES = 2;

  logic             clk;
  logic             reset_n;
  logic             cyc;
  logic             stb;
  logic             we;
  logic [1:0]       adr;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] dat_o;
  logic             ack_o;
  logic [WIDTH-1:0] pins;
  logic [WIDTH-1:0] port_o;
  logic [WIDTH-1:0] ddr_o;
  logic             irq_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [WIDTH-1:0] m_port;
  logic [WIDTH-1:0] m_ddr;
  logic [WIDTH-1:0] m_edge;
  logic [WIDTH-1:0] m_pins;

  gpia_wb_ctrl #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .cyc_i   (cyc),
    .stb_i   (stb),
    .we_i    (we),
    .adr_i   (adr),
    .dat_i   (wdat),
    .dat_o   (dat_o),
    .ack_o   (ack_o),
    .pins_i  (pins),
    .port_o  (port_o),
    .ddr_o   (ddr_o),
    .irq_o   (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] ref_read(input logic [1:0] a);
    case (a)
      2'd0:    return (m_ddr & m_port) | (~m_ddr & m_pins);
      2'd1:    return m_port;
      2'd2:    return m_ddr;
`ifdef GPIA_INPUT_EDGE_EN
      default: return m_edge;
`else
      default: return '0;
`endif
    endcase
  endfunction

  function automatic logic edge_feature();
`ifdef GPIA_INPUT_EDGE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus transfer starting just after an edge; returns ack seen after the
  // request edge and after the following edge, plus dat_o in the ack cycle.
  task automatic xfer(input logic w, input logic [1:0] a, input logic [WIDTH-1:0] d,
                      output logic ack_on, output logic ack_off, output logic [WIDTH-1:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    ack_on = ack_o;
    rd     = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    ack_off = ack_o;
  endtask

  task automatic test_reset();
    logic a1, a0;
    logic [WIDTH-1:0] rd;
    reset_n = 1'b0;
    pins    = 16'hFFFF;
    idle(2);
    checks++; if (port_o !== 16'h0) begin failures++;
      $display("FAIL reset_port: got %h want 0000", port_o); end
    checks++; if (ddr_o !== 16'h0) begin failures++;
      $display("FAIL reset_ddr: got %h want 0000", ddr_o); end
    checks++; if (ack_o !== 1'b0) begin failures++;
      $display("FAIL reset_ack: got %b want 0", ack_o); end
    checks++; if (dat_o !== 16'h0) begin failures++;
      $display("FAIL reset_dat: got %h want 0000", dat_o); end
    checks++; if (irq_o !== 1'b0) begin failures++;
      $display("FAIL reset_irq: got %b want 0", irq_o); end
    reset_n = 1'b1;
    m_port = '0; m_ddr = '0; m_pins = 16'hFFFF;
    m_edge = edge_feature() ? 16'hFFFF : 16'h0;
    idle(3);
    xfer(1'b0, 2'd0, '0, a1, a0, rd);
    checks++; if (rd !== 16'hFFFF) begin failures++;
      $display("FAIL reset_input_read: got %h want ffff", rd); end
  endtask

  task automatic test_port_ddr();
    logic a1, a0;
    logic [WIDTH-1:0] rd;
    pins = 16'h5A5A; m_pins = 16'h5A5A;
    xfer(1'b1, 2'd1, 16'hA5A5, a1, a0, rd);
    m_port = 16'hA5A5;
    checks++; if ({a1, a0} !== 2'b10) begin failures++;
      $display("FAIL port_write_ack: got %b want 10", {a1, a0}); end
    checks++; if (port_o !== 16'hA5A5) begin failures++;
      $display("FAIL port_o: got %h want a5a5", port_o); end
    xfer(1'b1, 2'd2, 16'h00FF, a1, a0, rd);
    m_ddr = 16'h00FF;
    checks++; if ({a1, a0} !== 2'b10) begin failures++;
      $display("FAIL ddr_write_ack: got %b want 10", {a1, a0}); end
    checks++; if (ddr_o !== 16'h00FF) begin failures++;
      $display("FAIL ddr_o: got %h want 00ff", ddr_o); end
    xfer(1'b0, 2'd0, '0, a1, a0, rd);
    checks++; if (rd !== 16'h5AA5) begin failures++;
      $display("FAIL input_mix_read: got %h want 5aa5", rd); end
    xfer(1'b0, 2'd1, '0, a1, a0, rd);
    checks++; if (rd !== 16'hA5A5) begin failures++;
      $display("FAIL port_read: got %h want a5a5", rd); end
    xfer(1'b0, 2'd2, '0, a1, a0, rd);
    checks++; if (rd !== 16'h00FF) begin failures++;
      $display("FAIL ddr_read: got %h want 00ff", rd); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] want;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      want = (i % 2 == 0) ? m_port : '0;
      checks++; if (ack_o !== ((i % 2) == 0)) begin failures++;
        $display("FAIL b2b_ack[%0d]: got %b want %b", i, ack_o, (i % 2) == 0); end
      checks++; if (dat_o !== want) begin failures++;
        $display("FAIL b2b_dat[%0d]: got %h want %h", i, dat_o, want); end
    end
    cyc = 1'b0; stb = 1'b0;
    idle(1);
  endtask

  task automatic test_sync_latency();
    logic a1, a0;
    logic [WIDTH-1:0] rd;
    xfer(1'b1, 2'd2, 16'h0000, a1, a0, rd);
    m_ddr = '0;
    pins = 16'h0000; idle(4);
    pins = 16'h0008; idle(1);
    xfer(1'b0, 2'd0, '0, a1, a0, rd);
    checks++; if (rd[3] !== 1'b0) begin failures++;
      $display("FAIL sync_early: got %b want 0", rd[3]); end
    pins = 16'h0000; idle(4);
    pins = 16'h0008; idle(SYNC_STAGES);
    xfer(1'b0, 2'd0, '0, a1, a0, rd);
    checks++; if (rd[3] !== 1'b1) begin failures++;
      $display("FAIL sync_late: got %b want 1", rd[3]); end
    m_pins = 16'h0008;
    if (edge_feature()) m_edge = m_edge | 16'h0008;
  endtask

  task automatic test_reset_during_ack();
    logic a1, a0;
    logic [WIDTH-1:0] rd;
    xfer(1'b1, 2'd1, 16'hA5A5, a1, a0, rd);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1;
    @(posedge clk); #1;
    checks++; if (ack_o !== 1'b1) begin failures++;
      $display("FAIL rst_ack_pre: got %b want 1", ack_o); end
    reset_n = 1'b0; we = 1'b1; wdat = 16'h1234;
    @(posedge clk); #1;
    checks++; if (ack_o !== 1'b0) begin failures++;
      $display("FAIL rst_ack_drop: got %b want 0", ack_o); end
    @(posedge clk); #1;
    checks++; if (port_o !== 16'h0000) begin failures++;
      $display("FAIL rst_write_discard: got %h want 0000", port_o); end
    checks++; if (ack_o !== 1'b0) begin failures++;
      $display("FAIL rst_ack_hold: got %b want 0", ack_o); end
    reset_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    m_port = '0; m_ddr = '0;
    m_edge = edge_feature() ? (m_pins) : '0;
    idle(4);
  endtask

  task automatic test_edge();
    logic a1, a0;
    logic [WIDTH-1:0] rd;
    pins = 16'h0000; m_pins = '0; idle(4);
    xfer(1'b1, 2'd3, 16'hFFFF, a1, a0, rd);
    checks++; if ({a1, a0} !== 2'b10) begin failures++;
      $display("FAIL edge_clr_ack: got %b want 10", {a1, a0}); end
    xfer(1'b0, 2'd3, '0, a1, a0, rd);
    checks++; if (rd !== 16'h0000) begin failures++;
      $display("FAIL edge_cleared: got %h want 0000", rd); end
    pins = 16'h0001; idle(4);
    xfer(1'b0, 2'd3, '0, a1, a0, rd);
    if (edge_feature()) begin
      checks++; if (rd !== 16'h0001) begin failures++;
        $display("FAIL edge_rise: got %h want 0001", rd); end
      checks++; if (irq_o !== 1'b1) begin failures++;
        $display("FAIL edge_irq_set: got %b want 1", irq_o); end
      pins = 16'h0000; idle(4);
      pins = 16'h0001; idle(2);
      xfer(1'b1, 2'd3, 16'h0001, a1, a0, rd);
      xfer(1'b0, 2'd3, '0, a1, a0, rd);
      checks++; if (rd !== 16'h0001) begin failures++;
        $display("FAIL edge_set_wins: got %h want 0001", rd); end
      xfer(1'b1, 2'd3, 16'h0001, a1, a0, rd);
      xfer(1'b0, 2'd3, '0, a1, a0, rd);
      checks++; if (rd !== 16'h0000) begin failures++;
        $display("FAIL edge_clear: got %h want 0000", rd); end
      checks++; if (irq_o !== 1'b0) begin failures++;
        $display("FAIL edge_irq_clr: got %b want 0", irq_o); end
    end else begin
      checks++; if (rd !== 16'h0000) begin failures++;
        $display("FAIL adr3_zero: got %h want 0000", rd); end
      checks++; if (irq_o !== 1'b0) begin failures++;
        $display("FAIL irq_off: got %b want 0", irq_o); end
    end
    m_pins = 16'h0001; m_edge = '0;
  endtask

  task automatic test_random();
    logic a1, a0, w;
    logic [1:0] a;
    logic [WIDTH-1:0] d, rd, np, exp_rd;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        np = WIDTH'($urandom);
        if (edge_feature()) m_edge = m_edge | (np & ~m_pins);
        m_pins = np;
        pins = np;
        idle(4);
      end else begin
        w = 1'($urandom_range(0, 1));
        a = 2'($urandom_range(0, 3));
        d = WIDTH'($urandom);
        exp_rd = ref_read(a);
        xfer(w, a, d, a1, a0, rd);
        checks++; if ({a1, a0} !== 2'b10) begin failures++;
          $display("FAIL rnd_ack[%0d]: got %b want 10", i, {a1, a0}); end
        if (!w) begin
          checks++; if (rd !== exp_rd) begin failures++;
            $display("FAIL rnd_read[%0d] adr %0d: got %h want %h", i, a, rd, exp_rd); end
        end else begin
          if (a == 2'd1) m_port = d;
          if (a == 2'd2) m_ddr = d;
          if (a == 2'd3 && edge_feature()) m_edge = m_edge & ~d;
        end
      end
      checks++; if (port_o !== m_port || ddr_o !== m_ddr) begin failures++;
        $display("FAIL rnd_regs[%0d]: got %h/%h want %h/%h", i, port_o, ddr_o, m_port, m_ddr); end
      checks++; if (irq_o !== (|m_edge)) begin failures++;
        $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq_o, |m_edge); end
    end
  endtask

  initial begin
    reset_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    pins = '0; m_port = '0; m_ddr = '0; m_edge = '0; m_pins = '0;
    #1;
    test_reset();
    test_port_ddr();
    test_back_to_back();
    test_sync_latency();
    test_reset_during_ack();
    test_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
